// File: rtl/thresholding_cfg_pkg.sv
// Shared types and address helpers for the thresholding configuration loader.
// Field widths collapse to zero when a dimension is 1; field_w() keeps vectors legal.
package thresholding_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        RD_OUT  = 3'd4,
        DONE    = 3'd5
    } state_t;

    function automatic int cf_bits(int c, int pe);
        return $clog2(c / pe);
    endfunction

    function automatic int pe_bits(int pe);
        return $clog2(pe);
    endfunction

    function automatic int t_bits(int n);
        return n;
    endfunction

    function automatic int field_w(int w);
        return (w > 0) ? w : 1;
    endfunction

    // {cf, pe, t, 2'b00}; a zero-width field contributes nothing because its shift is 0.
    function automatic logic [31:0] pack_addr(logic [31:0] cf, logic [31:0] pe,
                                              logic [31:0] t, int pe_w, int t_w);
        return ((((cf << pe_w) | pe) << t_w) | t) << 2;
    endfunction

endpackage

// File: rtl/thresholding_cfg_loader_if.sv
// Stream-in, config-port and readback-stream bundle of the threshold table loader.
// master = loader side, slave = stream source / thresholding core / readback sink.
interface thresholding_cfg_loader_if
    import thresholding_cfg_pkg::*;
#(
    parameter int N  = 2,
    parameter int K  = 8,
    parameter int C  = 4,
    parameter int PE = 2
);
    localparam int ADDR_BITS = cf_bits(C, PE) + pe_bits(PE) + t_bits(N) + 2;

    // Streams: a beat transfers on a rising edge where valid && ready; valid
    // never waits on ready, and data/last hold while valid is high and ready low.
    logic                 s_axis_tready;
    logic                 s_axis_tvalid;
    logic [K-1:0]         s_axis_tdata;
    logic                 s_axis_tlast;

    logic                 cfg_en;
    logic                 cfg_we;
    logic [ADDR_BITS-1:0] cfg_a;
    logic [K-1:0]         cfg_d;
    logic                 cfg_rack;
    logic [K-1:0]         cfg_q;

    logic                 m_axis_tready;
    logic                 m_axis_tvalid;
    logic [K-1:0]         m_axis_tdata;
    logic                 m_axis_tlast;

    modport master (
        output s_axis_tready,
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        output cfg_en, cfg_we, cfg_a, cfg_d,
        input  cfg_rack, cfg_q,
        input  m_axis_tready,
        output m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport slave (
        input  s_axis_tready,
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast,
        input  cfg_en, cfg_we, cfg_a, cfg_d,
        output cfg_rack, cfg_q,
        output m_axis_tready,
        input  m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

endinterface

// File: rtl/thresholding_cfg_addr_cnt.sv
// Nested t -> pe -> cf position counter shared by the write and readback passes.
// Every field wraps to 0 after its last index; last flags the final table entry.
module thresholding_cfg_addr_cnt #(
    parameter int CF    = 2,
    parameter int PE    = 2,
    parameter int T_CNT = 3,
    parameter int CF_W  = 1,
    parameter int PE_W  = 1,
    parameter int T_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [CF_W-1:0] cf,
    output logic [PE_W-1:0] pe,
    output logic [T_W-1:0]  t,
    output logic            last
);
    localparam logic [CF_W-1:0] CF_MAX = CF_W'(CF - 1);
    localparam logic [PE_W-1:0] PE_MAX = PE_W'(PE - 1);
    localparam logic [T_W-1:0]  T_MAX  = T_W'(T_CNT - 1);

    logic t_last, pe_last, cf_last;

    assign t_last  = (t == T_MAX);
    assign pe_last = (pe == PE_MAX);
    assign cf_last = (cf == CF_MAX);
    assign last    = t_last && pe_last && cf_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cf <= '0;
            pe <= '0;
            t  <= '0;
        end else if (inc) begin
            t <= t_last ? '0 : t + 1'b1;
            if (t_last) begin
                pe <= pe_last ? '0 : pe + 1'b1;
                if (pe_last) begin
                    cf <= cf_last ? '0 : cf + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/thresholding_cfg_loader.sv
// Streams a full threshold table into the thresholding core's config port.
// Define THRESHOLDING_CFG_READBACK_EN to also read the table back out on m_axis.
module thresholding_cfg_loader
    import thresholding_cfg_pkg::*;
#(
    parameter int N  = 2,
    parameter int K  = 8,
    parameter int C  = 4,
    parameter int PE = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    output logic   busy,
    output logic   done,
    output logic   err,
    output state_t dbg_state,
    thresholding_cfg_loader_if.master bus
);
    localparam int CF        = C / PE;
    localparam int CF_W      = cf_bits(C, PE);
    localparam int PE_W      = pe_bits(PE);
    localparam int CF_FW     = field_w(CF_W);
    localparam int PE_FW     = field_w(PE_W);
    localparam int ADDR_BITS = CF_W + PE_W + t_bits(N) + 2;

    state_t               state;
    logic [CF_FW-1:0]     cnt_cf;
    logic [PE_FW-1:0]     cnt_pe;
    logic [N-1:0]         cnt_t;
    logic                 cnt_last;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic                 s_fire;
    logic [ADDR_BITS-1:0] addr_now;

    logic                 cfg_en_q;
    logic                 cfg_we_q;
    logic [ADDR_BITS-1:0] cfg_a_q;
    logic [K-1:0]         cfg_d_q;

    assign bus.s_axis_tready = (state == WRITE);
    assign bus.cfg_en        = cfg_en_q;
    assign bus.cfg_we        = cfg_we_q;
    assign bus.cfg_a         = cfg_a_q;
    assign bus.cfg_d         = cfg_d_q;
    assign dbg_state         = state;

    assign s_fire   = (state == WRITE) && bus.s_axis_tvalid;
    assign cnt_clr  = (state == IDLE) && start;
    assign addr_now = ADDR_BITS'(pack_addr(32'(cnt_cf), 32'(cnt_pe), 32'(cnt_t), PE_W, N));

`ifdef THRESHOLDING_CFG_READBACK_EN
    logic         m_valid_q;
    logic [K-1:0] m_data_q;
    logic         m_last_q;
    logic         rd_fire;

    assign bus.m_axis_tvalid = m_valid_q;
    assign bus.m_axis_tdata  = m_data_q;
    assign bus.m_axis_tlast  = m_last_q;
    assign rd_fire           = (state == RD_OUT) && bus.m_axis_tready;
    assign cnt_inc           = s_fire || rd_fire;
`else
    logic unused_rd;

    assign bus.m_axis_tvalid = 1'b0;
    assign bus.m_axis_tdata  = '0;
    assign bus.m_axis_tlast  = 1'b0;
    assign cnt_inc           = s_fire;
    assign unused_rd         = ^{bus.cfg_rack, bus.cfg_q, bus.m_axis_tready};
`endif

    thresholding_cfg_addr_cnt #(
        .CF   (CF),
        .PE   (PE),
        .T_CNT((1 << N) - 1),
        .CF_W (CF_FW),
        .PE_W (PE_FW),
        .T_W  (N)
    ) u_addr_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cf  (cnt_cf),
        .pe  (cnt_pe),
        .t   (cnt_t),
        .last(cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cfg_en_q <= 1'b0;
            cfg_we_q <= 1'b0;
            cfg_a_q  <= '0;
            cfg_d_q  <= '0;
`ifdef THRESHOLDING_CFG_READBACK_EN
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            cfg_en_q <= 1'b0;
            cfg_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= WRITE;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                    end
                end
                WRITE: begin
                    if (bus.s_axis_tvalid) begin
                        cfg_en_q <= 1'b1;
                        cfg_we_q <= 1'b1;
                        cfg_a_q  <= addr_now;
                        cfg_d_q  <= bus.s_axis_tdata;
                        // A misplaced or missing tlast only flags; the table length is fixed.
                        if (bus.s_axis_tlast != cnt_last) begin
                            err <= 1'b1;
                        end
                        if (cnt_last) begin
`ifdef THRESHOLDING_CFG_READBACK_EN
                            state <= RD_REQ;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
`ifdef THRESHOLDING_CFG_READBACK_EN
                RD_REQ: begin
                    cfg_en_q <= 1'b1;
                    cfg_a_q  <= addr_now;
                    state    <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (bus.cfg_rack) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= bus.cfg_q;
                        m_last_q  <= cnt_last;
                        state     <= RD_OUT;
                    end
                end
                RD_OUT: begin
                    // The counter steps on this handshake, so cnt_last still names the beat on show.
                    if (bus.m_axis_tready) begin
                        m_valid_q <= 1'b0;
                        m_last_q  <= 1'b0;
                        state     <= cnt_last ? DONE : RD_REQ;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Randomized bench for thresholding_cfg_loader (N=2, K=8, C=4, PE=2).
// Expected writes/readbacks come from the channel-major table rule, not from the RTL.
module tb_thresholding_cfg_loader;
    import thresholding_cfg_pkg::*;

    localparam int N  = 2;
    localparam int K  = 8;
    localparam int C  = 4;
    localparam int PE = 2;
    localparam int NT = (1 << N) - 1;
    localparam int NB = C * NT;
    localparam int AW = $clog2(C / PE) + $clog2(PE) + N + 2;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   start = 1'b0;
    logic   busy, done, err;
    state_t dbg_state;

    thresholding_cfg_loader_if #(.N(N), .K(K), .C(C), .PE(PE)) bus ();

    thresholding_cfg_loader #(.N(N), .K(K), .C(C), .PE(PE)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .dbg_state(dbg_state),
        .bus      (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cyc=%0d)", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [AW+K-1:0] exp_q[$];
    logic [K:0]      rb_exp_q[$];
    int              wr_log[$];
    int              last_wr_cyc = 0;
    int              rb_acc_cyc = 0;
    int              run = 0;
    int              max_run = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Table position b: channel c = b / (2^N-1), threshold t = b % (2^N-1);
    // word address is (channel slot * 2^N + t) * 4 with slot = cf*PE + pe.
    function automatic int exp_addr(int b);
        int c  = b / NT;
        int t  = b % NT;
        int cf = c / PE;
        int pe = c % PE;
        return ((cf * PE + pe) * (1 << N) + t) * 4;
    endfunction

    function automatic logic [K-1:0] core_q(int a);
        return K'(a * 7 + 3);
    endfunction

    // ---------------- monitor ----------------
    int rd_out = 0;
    initial forever begin
        logic [AW+K-1:0] e;
        @(negedge clk);
        if (bus.cfg_en && bus.cfg_we) begin
            check("wr_expected", 64'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_addr", bus.cfg_a, e[AW+K-1:K]);
                check("wr_data", bus.cfg_d, e[K-1:0]);
            end
            wr_log.push_back(int'(bus.cfg_a));
            last_wr_cyc = cyc;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
`ifdef THRESHOLDING_CFG_READBACK_EN
        if (bus.cfg_en && !bus.cfg_we) begin
            rd_out++;
            check("one_outstanding", rd_out, 1);
        end
        if (bus.cfg_rack) rd_out--;
`endif
    end

    // ---------------- core model and readback sink ----------------
`ifdef THRESHOLDING_CFG_READBACK_EN
    initial forever begin
        int a;
        @(negedge clk);
        if (bus.cfg_en && !bus.cfg_we) begin
            a = int'(bus.cfg_a);
            repeat (3) @(posedge clk);
            #1;
            bus.cfg_rack = 1'b1;
            bus.cfg_q    = core_q(a);
            @(posedge clk);
            #1;
            bus.cfg_rack = 1'b0;
            bus.cfg_q    = K'($urandom);
        end
    end

    initial forever begin
        int stall;
        logic [K-1:0] held;
        logic [K:0] r;
        stall = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (bus.m_axis_tvalid) begin
                if (stall > 0) check("rb_stable", bus.m_axis_tdata, held);
                held = bus.m_axis_tdata;
                if (stall < 2) begin
                    bus.m_axis_tready = 1'b0;
                    stall++;
                end else begin
                    bus.m_axis_tready = 1'b1;
                    stall = 0;
                    check("rb_expected", 64'(rb_exp_q.size() > 0), 1);
                    if (rb_exp_q.size() > 0) begin
                        r = rb_exp_q.pop_front();
                        check("rb_data", bus.m_axis_tdata, r[K-1:0]);
                        check("rb_last", bus.m_axis_tlast, r[K]);
                    end
                    rb_acc_cyc = cyc;
                end
            end else begin
                bus.m_axis_tready = 1'b0;
            end
        end
    end
`endif

    // ---------------- drivers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [K-1:0] d, input logic l, input bit gaps);
        bit ok;
        int g;
        ok = 1'b0;
        if (gaps) begin
            g = $urandom_range(0, 2);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = l;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.s_axis_tready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        check("beat_accepted", 64'(ok), 1);
    endtask

    // Loads n_send beats; tlast on tlast_beat (-1 = none); err expected from err_from (-1 = never).
    task automatic run_load(input int tlast_beat, input bit gaps, input bit rand_data,
                            input int n_send, input int err_from, input int mid_start);
        logic [K-1:0] d;
        bit seen;
        int dc;
        wr_log.delete();
        max_run = 0;
`ifdef THRESHOLDING_CFG_READBACK_EN
        if (n_send == NB) begin
            for (int b = 0; b < NB; b++) rb_exp_q.push_back({1'(b == NB - 1), core_q(exp_addr(b))});
        end
`endif
        pulse_start();
        check("busy_after_start", busy, 1);
        check("err_cleared", err, 0);
        for (int b = 0; b < n_send; b++) begin
            d = rand_data ? K'($urandom) : K'(8'h10 + b);
            exp_q.push_back({AW'(exp_addr(b)), d});
            send_beat(d, b == tlast_beat, gaps);
            check("err_track", err, 64'(err_from >= 0 && b >= err_from));
            if (b == mid_start) begin
                pulse_start();
                check("busy_hold", busy, 1);
            end
        end
        if (n_send == NB) begin
            seen = 1'b0;
            dc = 0;
            for (int i = 0; i < 600 && !seen; i++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    dc = cyc;
                end
            end
            check("done_seen", 64'(seen), 1);
`ifdef THRESHOLDING_CFG_READBACK_EN
            check("done_timing", dc, rb_acc_cyc + 2);
`else
            check("done_timing", dc, last_wr_cyc + 1);
`endif
            check("busy_clear", busy, 0);
            check("err_final", err, 64'(err_from >= 0));
            check("exp_drained", exp_q.size(), 0);
            check("wr_count", wr_log.size(), NB);
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.cfg_rack      = 1'b0;
        bus.cfg_q         = '0;
        bus.m_axis_tready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_tready", bus.s_axis_tready, 0);
        check("rst_cfg_en", bus.cfg_en, 0);
        check("rst_cfg_we", bus.cfg_we, 0);
        check("rst_cfg_a", bus.cfg_a, 0);
        check("rst_cfg_d", bus.cfg_d, 0);
        check("rst_m_tvalid", bus.m_axis_tvalid, 0);
        check("rst_m_tdata", bus.m_axis_tdata, 0);
        check("rst_m_tlast", bus.m_axis_tlast, 0);
        check("rst_state", dbg_state, IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Addressing: back-to-back 0x10.. with tlast on the final beat.
        run_load(NB - 1, 1'b0, 1'b0, NB, -1, -1);
        check("wr_back_to_back", max_run, NB);
        if (wr_log.size() == NB) begin
            check("beat4_addr", wr_log[4], 20);
            check("beat6_addr", wr_log[6], 32);
            check("beat11_addr", wr_log[11], 56);
        end

        // Random bubbles on tvalid with random data.
        run_load(NB - 1, 1'b1, 1'b1, NB, -1, -1);

        // Early tlast on beat 5, plus a start pulse mid-load that must be ignored.
        run_load(5, 1'b0, 1'b1, NB, 5, 8);

        // Missing tlast on the final beat.
        run_load(-1, 1'b1, 1'b1, NB, NB - 1, -1);

        // Reset after beat 7, then a clean reload from address 0.
        run_load(NB - 1, 1'b0, 1'b1, 8, -1, -1);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_cfg_en", bus.cfg_en, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_tready", bus.s_axis_tready, 0);
        check("rst_mid_drained", exp_q.size(), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_load(NB - 1, 1'b1, 1'b1, NB, -1, -1);
        if (wr_log.size() > 0) check("restart_addr0", wr_log[0], 0);

`ifdef THRESHOLDING_CFG_READBACK_EN
        check("rb_drained", rb_exp_q.size(), 0);
`else
        check("m_tvalid_off", bus.m_axis_tvalid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
